// File: rtl/result_viewer_pkg.sv
// Shared types and constants for the result-matrix viewer: display modes,
// the status/unwritten display patterns and the 32-bit display word packer.
package result_viewer_pkg;

  typedef enum logic {
    VALUE  = 1'b0,
    STATUS = 1'b1
  } disp_mode_e;

  localparam logic [7:0]  STATUS_TAG    = 8'h5A;
  localparam logic [15:0] UNWRITTEN_PAT = 16'hEEEE;

  function automatic logic [31:0] pack_disp(input logic [7:0]  hi,
                                            input logic [7:0]  mid,
                                            input logic [15:0] lo);
    return {hi, mid, lo};
  endfunction

endpackage

// File: rtl/result_viewer_button_debouncer.sv
// Raw push-button conditioner: 2-flop synchroniser, stability counter and
// rising-edge detector giving one press_pulse per accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             stable, stable_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press_pulse = stable & ~stable_d;

endmodule

// File: rtl/result_viewer.sv
// Result-matrix store and button-driven browser feeding seven_segment_controller.
// Optional build macro RESULT_VIEWER_AUTOSCAN_EN adds idle-time cursor auto-advance.
module result_viewer
  import result_viewer_pkg::*;
#(
  parameter int ELEM_W          = 8,
  parameter int ROWS            = 32,
  parameter int COLS            = 32,
  parameter int DEBOUNCE_CYCLES = 250000
`ifdef RESULT_VIEWER_AUTOSCAN_EN
  ,
  parameter int SCAN_CYCLES     = 100_000_000
`endif
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clear,
  input  logic [$clog2(ROWS):0]    dim_rows,
  input  logic [$clog2(COLS):0]    dim_cols,
  input  logic                     wr_valid,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [ELEM_W-1:0]        wr_data,
  input  logic                     btn_next,
  input  logic                     btn_prev,
  input  logic                     btn_mode,
  output logic [31:0]              disp_out,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic                     all_written,
  output logic                     err_oob
);

  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int AW     = RW + CW;
  localparam int N      = ROWS * COLS;
  localparam int AREA_W = AW + 2;

  localparam logic [RW:0]        R_ONE   = (RW + 1)'(1);
  localparam logic [CW:0]        C_ONE   = (CW + 1)'(1);
  localparam logic [RW:0]        R_MAX   = (RW + 1)'(ROWS);
  localparam logic [CW:0]        C_MAX   = (CW + 1)'(COLS);
  localparam logic [AREA_W-1:0]  CNT_ONE = AREA_W'(1);

  logic next_p, prev_p, mode_p;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk_in(clk_in), .rst_in(rst_in), .raw(btn_next), .press_pulse(next_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk_in(clk_in), .rst_in(rst_in), .raw(btn_prev), .press_pulse(prev_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_in(clk_in), .rst_in(rst_in), .raw(btn_mode), .press_pulse(mode_p));

  logic [RW:0]         dim_r, sat_r;
  logic [CW:0]         dim_c, sat_c;
  logic [N-1:0]        written;
  logic [AREA_W-1:0]   count, area;
  logic [ELEM_W-1:0]   mem [N];
  logic [ELEM_W-1:0]   rd_q;
  logic [AW-1:0]       wr_addr, cur_addr;
  logic                in_range, wr_ok, wr_bad, wr_new, wr_hit;
  disp_mode_e          mode, mode_nx;
  logic [RW-1:0]       cur_r_nx;
  logic [CW-1:0]       cur_c_nx;
  logic                adv, move_fwd, move_bwd;

  logic [RW-1:0]       s1_row;
  logic [CW-1:0]       s1_col;
  logic                s1_written, s1_err;
  disp_mode_e          s1_mode;
  logic [AREA_W-1:0]   s1_count;
  logic [31:0]         disp_nx;

  assign sat_r = (dim_rows == '0) ? R_ONE : (dim_rows > R_MAX) ? R_MAX : dim_rows;
  assign sat_c = (dim_cols == '0) ? C_ONE : (dim_cols > C_MAX) ? C_MAX : dim_cols;

  assign wr_addr  = {wr_row, wr_col};
  assign cur_addr = {cur_row, cur_col};
  assign in_range = ({1'b0, wr_row} < dim_r) && ({1'b0, wr_col} < dim_c);
  assign wr_ok    = wr_valid && !clear && in_range;
  assign wr_bad   = wr_valid && !clear && !in_range;
  assign wr_new   = wr_ok && !written[wr_addr];
  assign wr_hit   = wr_ok && (wr_addr == cur_addr);
  assign area     = AREA_W'(dim_r) * AREA_W'(dim_c);

`ifdef RESULT_VIEWER_AUTOSCAN_EN
  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic [SCAN_W-1:0] idle_cnt;
  logic              any_press, scan_p;

  assign any_press = next_p | prev_p | mode_p;
  assign scan_p    = (mode == VALUE) && !any_press && (idle_cnt == SCAN_LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idle_cnt <= '0;
    end else if (any_press || mode != VALUE || idle_cnt == SCAN_LAST) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + SCAN_W'(1);
    end
  end

  assign adv = next_p | scan_p;
`else
  assign adv = next_p;
`endif

  // Opposing presses in the same cycle cancel out.
  assign move_fwd = adv & ~prev_p;
  assign move_bwd = prev_p & ~next_p;

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_r_nx = cur_row;
    cur_c_nx = cur_col;
    mode_nx  = mode;
    if (mode_p) mode_nx = (mode == VALUE) ? STATUS : VALUE;
    if (move_fwd) begin
      if ({1'b0, cur_col} >= dim_c - C_ONE) begin
        cur_c_nx = '0;
        cur_r_nx = ({1'b0, cur_row} >= dim_r - R_ONE) ? '0 : cur_row + RW'(1);
      end else begin
        cur_c_nx = cur_col + CW'(1);
      end
    end else if (move_bwd) begin
      if (cur_col == '0) begin
        cur_c_nx = CW'(dim_c - C_ONE);
        cur_r_nx = (cur_row == '0) ? RW'(dim_r - R_ONE) : cur_row - RW'(1);
      end else begin
        cur_c_nx = cur_col - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dim_r       <= R_MAX;
      dim_c       <= C_MAX;
      written     <= '0;
      count       <= '0;
      err_oob     <= 1'b0;
      all_written <= 1'b0;
      cur_row     <= '0;
      cur_col     <= '0;
      mode        <= VALUE;
    end else begin
      mode <= mode_nx;
      if (clear) begin
        dim_r       <= sat_r;
        dim_c       <= sat_c;
        written     <= '0;
        count       <= '0;
        err_oob     <= 1'b0;
        all_written <= 1'b0;
        cur_row     <= '0;
        cur_col     <= '0;
      end else begin
        if (wr_new) begin
          written[wr_addr] <= 1'b1;
          count            <= count + CNT_ONE;
        end
        if (wr_bad) err_oob <= 1'b1;
        all_written <= (count == area);
        cur_row     <= cur_r_nx;
        cur_col     <= cur_c_nx;
      end
    end
  end

  // NOTE: the element RAM has no reset; validity comes from the written
  // bitmap, which keeps the array mappable onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    rd_q <= wr_hit ? wr_data : mem[cur_addr];
  end

  // Stage 1 aligns cursor, mode and status with the RAM read; stage 2 is disp_out.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_row     <= '0;
      s1_col     <= '0;
      s1_written <= 1'b0;
      s1_mode    <= VALUE;
      s1_count   <= '0;
      s1_err     <= 1'b0;
      disp_out   <= '0;
    end else begin
      s1_row     <= cur_row;
      s1_col     <= cur_col;
      s1_written <= written[cur_addr] | wr_hit;
      s1_mode    <= mode;
      s1_count   <= count;
      s1_err     <= err_oob;
      disp_out   <= disp_nx;
    end
  end

  always_comb begin
    disp_nx = pack_disp(STATUS_TAG, {7'b0, s1_err}, 16'(s1_count));
    if (s1_mode == VALUE)
      disp_nx = pack_disp(8'(s1_row), 8'(s1_col),
                          s1_written ? 16'(rd_q) : UNWRITTEN_PAT);
  end

endmodule

// File: tb/tb_result_viewer.sv
// Directed self-checking bench for result_viewer with a 4x4 store and
// DEBOUNCE_CYCLES=4; expected values are hand-computed constants.
module tb_result_viewer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        clear;
  logic [2:0]  dim_rows, dim_cols;
  logic        wr_valid;
  logic [1:0]  wr_row, wr_col;
  logic [7:0]  wr_data;
  logic        btn_next, btn_prev, btn_mode;
  logic [31:0] disp_out;
  logic [1:0]  cur_row, cur_col;
  logic        all_written, err_oob;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  result_viewer #(
    .ELEM_W(8), .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear(clear),
    .dim_rows(dim_rows), .dim_cols(dim_cols),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode),
    .disp_out(disp_out), .cur_row(cur_row), .cur_col(cur_col),
    .all_written(all_written), .err_oob(err_oob)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // All drivers below start and end on a falling edge.
  task automatic do_clear(input logic [2:0] r, input logic [2:0] c);
    clear = 1'b1; dim_rows = r; dim_cols = c;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
    wr_valid = 1'b1; wr_row = r; wr_col = c; wr_data = d;
    tick(1);
    wr_valid = 1'b0;
  endtask

  task automatic press(input int which);
    if (which == 0) btn_next = 1'b1;
    if (which == 1) btn_prev = 1'b1;
    if (which == 2) btn_mode = 1'b1;
    tick(10);
    btn_next = 1'b0; btn_prev = 1'b0; btn_mode = 1'b0;
    tick(10);
  endtask

  initial begin
    rst_in = 1'b0; clear = 1'b0; dim_rows = '0; dim_cols = '0;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_mode = 1'b0;
    tick(2);
    check("rst_disp", disp_out, 32'h0);
    check("rst_cursor", {cur_row, cur_col}, 4'h0);
    check("rst_flags", {all_written, err_oob}, 2'b00);
    rst_in = 1'b1;
    tick(3);
    check("idle_disp", disp_out, 32'h0000_EEEE);

    // 2x3 browse with wrap
    do_clear(3'd2, 3'd3);
    do_write(2'd1, 2'd2, 8'h7F);
    for (int i = 0; i < 5; i++) press(0);
    check("next5_cursor", {cur_row, cur_col}, {2'd1, 2'd2});
    check("next5_disp", disp_out, 32'h0102_007F);
    press(0);
    check("wrap_fwd", {cur_row, cur_col}, {2'd0, 2'd0});
    press(1);
    check("wrap_bwd", {cur_row, cur_col}, {2'd1, 2'd2});

    // glitch and simultaneous presses
    btn_next = 1'b1; tick(3); btn_next = 1'b0; tick(12);
    check("glitch", {cur_row, cur_col}, {2'd1, 2'd2});
    btn_next = 1'b1; btn_prev = 1'b1; tick(10);
    btn_next = 1'b0; btn_prev = 1'b0; tick(10);
    check("next_prev", {cur_row, cur_col}, {2'd1, 2'd2});

    // write to displayed cell goes through the bypass
    do_write(2'd1, 2'd2, 8'h33);
    tick(1);
    check("bypass", disp_out, 32'h0102_0033);

    // 2x2 fill with one rewrite
    do_clear(3'd2, 3'd2);
    check("clear_cursor", {cur_row, cur_col}, 4'h0);
    do_write(2'd0, 2'd0, 8'h01);
    do_write(2'd0, 2'd1, 8'h02);
    do_write(2'd0, 2'd0, 8'h03);
    do_write(2'd1, 2'd0, 8'h04);
    tick(1);
    check("partial_fill", {31'b0, all_written}, 32'h0);
    do_write(2'd1, 2'd1, 8'h05);
    tick(1);
    check("all_written", {31'b0, all_written}, 32'h1);
    press(2);
    check("status_full", disp_out, 32'h5A00_0004);
    press(2);
    check("rewrite_val", disp_out, 32'h0000_0003);

    // out-of-range write
    do_clear(3'd3, 3'd3);
    do_write(2'd3, 2'd0, 8'h11);
    check("oob_set", {31'b0, err_oob}, 32'h1);
    press(2);
    check("status_oob", disp_out, 32'h5A01_0000);
    do_clear(3'd3, 3'd3);
    check("oob_cleared", {31'b0, err_oob}, 32'h0);
    tick(3);
    check("status_clr", disp_out, 32'h5A00_0000);

    // clear and write in the same cycle
    press(2);
    clear = 1'b1; dim_rows = 3'd2; dim_cols = 3'd2;
    wr_valid = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h55;
    tick(1);
    clear = 1'b0; wr_valid = 1'b0;
    tick(3);
    check("clr_wr_cell", disp_out, 32'h0000_EEEE);
    press(2);
    check("clr_wr_count", disp_out, 32'h5A00_0000);

    // async reset in the middle of a write
    press(0);
    check("pre_rst_cur", {cur_row, cur_col}, {2'd0, 2'd1});
    do_write(2'd2, 2'd0, 8'h66);
    check("pre_rst_oob", {31'b0, err_oob}, 32'h1);
    wr_valid = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h77;
    #2 rst_in = 1'b0;
    #1;
    check("async_disp", disp_out, 32'h0);
    check("async_cursor", {cur_row, cur_col}, 4'h0);
    check("async_flags", {all_written, err_oob}, 2'b00);
    tick(1);
    wr_valid = 1'b0; rst_in = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/result_viewer.md
Name: result_viewer

Overview:
Parametrised result-matrix store and on-board browser for the matrix-multiply datapath.
- Captures element writes from the algorithm's output stream (row, col, value).
- Tracks which elements have been written and counts distinct writes.
- Lets the user step through the matrix with debounced buttons.
- Drives a 32-bit packed value into seven_segment_controller.
- Replaces the ad-hoc out_array / btnu stepping logic at top level. Adds runtime matrix dimensions, bidirectional navigation with wrap-around, a written-flag bitmap, a status display mode, and out-of-range write detection.

Parameters:
ELEM_W, 8, element width in bits (1..16)
ROWS, 32, maximum rows (power of two, <=256)
COLS, 32, maximum columns (power of two, <=256)
DEBOUNCE_CYCLES, 250000, cycles a raw button must hold stable before it is accepted

Ports:
clk_in  in  1  system clock (algorithm clock domain)
rst_in  in  1  reset, asynchronous, active-low
clear  in  1  one-cycle pulse: start new result, latch dims, invalidate store
dim_rows  in  $clog2(ROWS)+1  active row count, sampled on clear
dim_cols  in  $clog2(COLS)+1  active column count, sampled on clear
wr_valid  in  1  element write strobe
wr_row  in  $clog2(ROWS)  write row address
wr_col  in  $clog2(COLS)  write column address
wr_data  in  ELEM_W  element value
btn_next  in  1  raw button: advance cursor
btn_prev  in  1  raw button: retreat cursor
btn_mode  in  1  raw button: toggle display mode
disp_out  out  32  packed value for seven_segment_controller
cur_row  out  $clog2(ROWS)  cursor row
cur_col  out  $clog2(COLS)  cursor column
all_written  out  1  every active element written since last clear
err_oob  out  1  sticky: a write fell outside the active dims

Behaviour:
- Reset (async, rst_in=0):
  - Cursor 0,0; mode=VALUE; dims=ROWS,COLS.
  - All written flags cleared; count=0.
  - Outputs: all_written=0, err_oob=0, disp_out=0.
  - Store contents are don't-care; unwritten cells display as unwritten.
- Store: ROWS*COLS x ELEM_W RAM with 1-cycle synchronous read, plus a ROWS*COLS written-flag bitmap in flops.
- Write on wr_valid when wr_row<dim_rows and wr_col<dim_cols:
  - Store the value.
  - If the flag was clear: set it and increment count.
  - A rewrite updates the value without changing count.
- Write outside the active dims: dropped; err_oob is set and stays set until clear or reset.
- all_written = (count == dim_rows*dim_cols). It is registered and asserts 1 cycle after the completing write.
- clear:
  - Latches dims; a dim of 0 or one above the maximum is saturated to 1 or to ROWS/COLS.
  - Zeroes flags, count, cursor and err_oob in one cycle.
  - A wr_valid in the same cycle as clear is ignored.
- Buttons: each passes through a debouncer, then a rising-edge detector, giving one press pulse per physical press.
- Cursor, row-major within the active dims:
  - next: col+1. Past dim_cols-1, col wraps to 0 and row advances. Past dim_rows-1, row wraps to 0.
  - prev is the mirror: from 0,0 it goes to dim_rows-1, dim_cols-1.
  - next and prev pulses in the same cycle: no move.
- Mode: the mode press toggles VALUE/STATUS.
- disp_out is registered, updated 2 cycles after a cursor/mode change (RAM read + output register).
  - VALUE mode:
    - [31:24] = cur_row, zero-extended.
    - [23:16] = cur_col, zero-extended.
    - [15:0] = value zero-extended when written, else 16'hEEEE.
  - STATUS mode:
    - [31:24] = 8'h5A.
    - [23:16] = {7'b0, err_oob}.
    - [15:0] = count.
- Write to the displayed cell: a write-first bypass shows the new value 2 cycles after wr_valid.

Optional Feature:
RESULT_VIEWER_AUTOSCAN_EN
- Defined: adds parameter SCAN_CYCLES (default 100_000_000). While mode=VALUE and no button press has occurred for SCAN_CYCLES cycles, the cursor auto-advances as for next, every SCAN_CYCLES cycles. Any press restarts the idle timer.
- Undefined: the cursor moves only on presses; no timer logic.

Decomposition:
- Package result_viewer_pkg:
  - disp_mode_e enum {VALUE, STATUS}.
  - Constants STATUS_TAG=8'h5A and UNWRITTEN_PAT=16'hEEEE.
  - Function packing row/col/value into the 32-bit display word.
- Sub-module button_debouncer (param DEBOUNCE_CYCLES; ports clk_in, rst_in, raw, press_pulse): 2-flop synchroniser, stability counter, rising-edge pulse. Instantiated three times.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, clear with dims 2x3, write (1,2)=0x7F, press next 5 times -> cursor 1,2; disp_out=32'h0102_007F.
- dims 2x3, cursor 1,2, press next -> cursor 0,0; press prev -> cursor 1,2.
- dims 2x2. Write all four cells, with (0,0) written twice -> all_written=1 one cycle after the 4th distinct write; STATUS shows 32'h5A00_0004.
- dims 3x3, write (3,0) -> err_oob=1, count unchanged; STATUS shows 32'h5A01_0000; clear -> err_oob=0.
- Button glitch shorter than 4 cycles -> no move. Next and prev pressed in the same cycle -> no move.
- clear and wr_valid in the same cycle -> write ignored, count=0, cell shows 16'hEEEE. Assert rst_in mid-write -> all outputs reset immediately, asynchronously.
